// File: rtl/neureka_column_serializer.sv
// -----------------------------------------------------------------------------
// neureka_column_serializer
//
// Collects output beats from NR_COL accumulator column streams and forwards
// them one column at a time onto a single store stream. A per-job column mask
// selects which columns take part. Disabled columns are skipped without a
// bubble. The column sweep is repeated nb_rounds times. An optional one-entry
// output register decouples the store stream from the column streams.
//
// Ports:
//   clk_i, rst_i, clear_i  clock, synchronous active-high reset, soft clear
//   start_i                single-cycle job start (sampled in IDLE only)
//   col_mask_i             enabled columns, latched at start
//   nb_rounds_i            number of full sweeps, latched at start
//   in_valid_i/in_ready_o  per-column handshake
//   in_data_i/in_strb_i    per-column payload, column c at slice c
//   out_valid_o/out_ready_i, out_data_o/out_strb_o   store stream
//   col_idx_o              column currently selected
//   busy_o                 high while a job is running
//   done_o                 one-cycle end-of-job pulse
// -----------------------------------------------------------------------------
module neureka_column_serializer #(
    parameter int  NR_COL     = 9,
    parameter int  DATA_WIDTH = 256,
    parameter int  CNT_WIDTH  = 8,
    parameter int  OUT_REG    = 0,
    localparam int IDX_W      = (NR_COL > 1) ? $clog2(NR_COL) : 1,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [NR_COL-1:0]            col_mask_i,
    input  logic [CNT_WIDTH-1:0]         nb_rounds_i,
    input  logic [NR_COL-1:0]            in_valid_i,
    input  logic [NR_COL*DATA_WIDTH-1:0] in_data_i,
    input  logic [NR_COL*STRB_W-1:0]     in_strb_i,
    output logic [NR_COL-1:0]            in_ready_o,
    output logic                         out_valid_o,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic [STRB_W-1:0]            out_strb_o,
    input  logic                         out_ready_i,
    output logic [IDX_W-1:0]             col_idx_o,
    output logic                         busy_o,
    output logic                         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [NR_COL-1:0]      mask_reg;
    logic [CNT_WIDTH-1:0]   rounds_reg;
    logic [CNT_WIDTH-1:0]   round_cnt_reg;
    logic [IDX_W-1:0]       ptr_reg;

    logic                   busy;
    logic                   sel_valid;
    logic                   sel_ready;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [STRB_W-1:0]      sel_strb;
    logic                   in_hs;
    logic                   final_beat;
    logic                   job_end;

    logic                   has_next;
    logic [IDX_W-1:0]       next_ptr;
    logic [IDX_W-1:0]       first_ptr;
    logic [IDX_W-1:0]       start_ptr;

    logic [DATA_WIDTH-1:0]  col_data [NR_COL];
    logic [STRB_W-1:0]      col_strb [NR_COL];

    // Per-column views of the flattened input buses, and the per-column ready:
    // only the selected column can ever see ready.
    generate
        for (genvar gi = 0; gi < NR_COL; gi++) begin : g_col
            assign col_data[gi]   = in_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign col_strb[gi]   = in_strb_i[gi*STRB_W +: STRB_W];
            assign in_ready_o[gi] = sel_ready & (ptr_reg == IDX_W'(gi));
        end
    endgenerate

    assign busy      = (state_reg == RUN);
    assign busy_o    = busy;
    assign done_o    = (state_reg == DONE);
    assign col_idx_o = ptr_reg;

    // Column multiplexer driven by the pointer.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        for (int c = 0; c < NR_COL; c++) begin
            if (ptr_reg == IDX_W'(c)) begin
                sel_valid = in_valid_i[c];
                sel_data  = col_data[c];
                sel_strb  = col_strb[c];
            end
        end
    end

    // Scanning downwards leaves the lowest qualifying index in each result:
    // the next enabled column above ptr, and the lowest enabled column.
    always_comb begin
        has_next  = 1'b0;
        next_ptr  = '0;
        first_ptr = '0;
        start_ptr = '0;
        for (int c = NR_COL - 1; c >= 0; c--) begin
            if (mask_reg[c]) begin
                first_ptr = IDX_W'(c);
                if (IDX_W'(c) > ptr_reg) begin
                    has_next = 1'b1;
                    next_ptr = IDX_W'(c);
                end
            end
            if (col_mask_i[c]) begin
                start_ptr = IDX_W'(c);
            end
        end
    end

    // The highest enabled column in the last round closes the job.
    assign final_beat = ~has_next & (round_cnt_reg == (rounds_reg - CNT_WIDTH'(1)));
    assign in_hs      = sel_valid & sel_ready;

    generate
        if (OUT_REG == 0) begin : g_pass
            assign sel_ready   = busy & out_ready_i;
            assign out_valid_o = busy & sel_valid;
            assign out_data_o  = busy ? sel_data : '0;
            assign out_strb_o  = busy ? sel_strb : '0;
            assign job_end     = in_hs & final_beat;
        end else begin : g_reg
            logic                  full_reg;
            logic [DATA_WIDTH-1:0] data_reg;
            logic [STRB_W-1:0]     strb_reg;
            // Set once the final beat has been pushed; blocks further input
            // while the job waits for that beat to leave the register.
            logic                  tail_reg;

            assign sel_ready   = busy & ~tail_reg & (~full_reg | out_ready_i);
            assign out_valid_o = full_reg;
            assign out_data_o  = data_reg;
            assign out_strb_o  = strb_reg;
            assign job_end     = tail_reg & full_reg & out_ready_i;

            always_ff @(posedge clk_i) begin
                if (rst_i || clear_i) begin
                    full_reg <= 1'b0;
                    data_reg <= '0;
                    strb_reg <= '0;
                    tail_reg <= 1'b0;
                end else begin
                    // A push refills the entry even when it is popped in the
                    // same cycle, giving one beat per cycle.
                    if (in_hs) begin
                        full_reg <= 1'b1;
                        data_reg <= sel_data;
                        strb_reg <= sel_strb;
                    end else if (out_ready_i) begin
                        full_reg <= 1'b0;
                    end

                    if (!busy) begin
                        tail_reg <= 1'b0;
                    end else if (in_hs && final_beat) begin
                        tail_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_reg     <= IDLE;
            mask_reg      <= '0;
            rounds_reg    <= '0;
            round_cnt_reg <= '0;
            ptr_reg       <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        if ((|col_mask_i) && (|nb_rounds_i)) begin
                            state_reg     <= RUN;
                            mask_reg      <= col_mask_i;
                            rounds_reg    <= nb_rounds_i;
                            ptr_reg       <= start_ptr;
                            round_cnt_reg <= '0;
                        end else begin
                            state_reg <= DONE;
                        end
                    end
                end
                RUN: begin
                    // The final beat does not bump round_cnt, so the maximum
                    // round count never wraps the counter.
                    if (in_hs && !final_beat) begin
                        if (has_next) begin
                            ptr_reg <= next_ptr;
                        end else begin
                            ptr_reg       <= first_ptr;
                            round_cnt_reg <= round_cnt_reg + CNT_WIDTH'(1);
                        end
                    end
                    if (job_end) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neureka_column_serializer.sv
// -----------------------------------------------------------------------------
// tb_neureka_column_serializer
//
// Drives two instances of the serializer (pass-through and registered output)
// with per-column sources whose payload is a pure function of (job, column,
// beat number). The expected store stream is built from the mask/rounds rules
// directly: for each round, each enabled column in ascending order.
// -----------------------------------------------------------------------------
module tb_neureka_column_serializer;

    localparam int NR_COL = 9;
    localparam int DW     = 32;
    localparam int CW     = 8;
    localparam int SW     = DW / 8;
    localparam int IW     = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   clear = 1'b0;
    logic                   start = 1'b0;
    logic [NR_COL-1:0]      col_mask = '0;
    logic [CW-1:0]          nb_rounds = '0;
    logic [NR_COL-1:0]      in_valid = '0;
    logic [NR_COL*DW-1:0]   in_data = '0;
    logic [NR_COL*SW-1:0]   in_strb = '0;
    logic                   out_ready = 1'b0;
    int                     cur = 0;

    logic                   start0, start1;
    logic [NR_COL-1:0]      valid0, valid1, rdy0, rdy1;
    logic                   ov0, ov1, busy0, busy1, done0, done1;
    logic [DW-1:0]          od0, od1;
    logic [SW-1:0]          os0, os1;
    logic [IW-1:0]          ci0, ci1;

    logic [NR_COL-1:0]      o_ready;
    logic                   o_valid, o_busy, o_done;
    logic [DW-1:0]          o_data;
    logic [SW-1:0]          o_strb;
    logic [IW-1:0]          o_idx;

    int n_checks = 0;
    int n_errors = 0;
    int salt = 0;

    always #5 clk = ~clk;

    assign start0 = (cur == 0) & start;
    assign start1 = (cur == 1) & start;
    assign valid0 = (cur == 0) ? in_valid : '0;
    assign valid1 = (cur == 1) ? in_valid : '0;

    neureka_column_serializer #(
        .NR_COL(NR_COL), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .OUT_REG(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start0),
        .col_mask_i(col_mask), .nb_rounds_i(nb_rounds),
        .in_valid_i(valid0), .in_data_i(in_data), .in_strb_i(in_strb),
        .in_ready_o(rdy0), .out_valid_o(ov0), .out_data_o(od0),
        .out_strb_o(os0), .out_ready_i(out_ready), .col_idx_o(ci0),
        .busy_o(busy0), .done_o(done0)
    );

    neureka_column_serializer #(
        .NR_COL(NR_COL), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .OUT_REG(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start1),
        .col_mask_i(col_mask), .nb_rounds_i(nb_rounds),
        .in_valid_i(valid1), .in_data_i(in_data), .in_strb_i(in_strb),
        .in_ready_o(rdy1), .out_valid_o(ov1), .out_data_o(od1),
        .out_strb_o(os1), .out_ready_i(out_ready), .col_idx_o(ci1),
        .busy_o(busy1), .done_o(done1)
    );

    always_comb begin
        if (cur == 0) begin
            o_ready = rdy0; o_valid = ov0; o_data = od0; o_strb = os0;
            o_idx = ci0; o_busy = busy0; o_done = done0;
        end else begin
            o_ready = rdy1; o_valid = ov1; o_data = od1; o_strb = os1;
            o_idx = ci1; o_busy = busy1; o_done = done1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (unit %0d, t=%0t)", tag, got, exp, cur, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int s, input int c, input int k);
        logic [31:0] v;
        v = (32'(s) * 32'h9E3779B1) ^ (32'(c) << 28) ^ (32'(k) * 32'h85EBCA6B) ^ 32'(c * 16'h1111);
        return v;
    endfunction

    function automatic logic [SW-1:0] beat_strb(input int s, input int c, input int k);
        logic [SW-1:0] v;
        v = SW'(s * 7 + c * 3 + k * 5);
        return v;
    endfunction

    task automatic set_beat(input int c, input int k);
        in_data[c*DW +: DW] = beat_data(salt, c, k);
        in_strb[c*SW +: SW] = beat_strb(salt, c, k);
    endtask

    // One job on unit u. clear_at > 0 aborts the job with clear_i once that
    // many output beats have been received.
    task automatic run_job(input int u, input logic [NR_COL-1:0] m, input int r,
                           input int vpct, input int rpct, input int clear_at);
        int exp_col[$];
        int exp_k[$];
        int src_k[NR_COL];
        int n_out, idx, done_idx, last_out_idx, first_out_idx, first_in_idx, busy_cnt;
        logic              hold_valid;
        logic [DW-1:0]     hold_data;
        logic [SW-1:0]     hold_strb;
        logic [NR_COL-1:0] hs;

        salt++;
        for (int rr = 0; rr < r; rr++) begin
            for (int c = 0; c < NR_COL; c++) begin
                if (m[c]) begin
                    exp_col.push_back(c);
                    exp_k.push_back(rr);
                end
            end
        end
        n_out = 0; done_idx = -1; last_out_idx = -1; first_out_idx = -1;
        first_in_idx = -1; busy_cnt = 0; hold_valid = 1'b0;
        hold_data = '0; hold_strb = '0;

        cur = u;
        col_mask = m;
        nb_rounds = CW'(r);
        for (int c = 0; c < NR_COL; c++) begin
            src_k[c] = 0;
            in_valid[c] = ($urandom_range(99) < vpct);
            set_beat(c, 0);
        end
        out_ready = ($urandom_range(99) < rpct);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        idx = 0;
        while (idx < 4000) begin
            @(negedge clk);
            hs = in_valid & o_ready;
            check_eq("unsel_ready", 64'(o_ready & ~m), 64'd0);
            if (o_busy) busy_cnt++;
            if (hs != '0 && first_in_idx < 0) first_in_idx = idx;
            if (o_valid && first_out_idx < 0) first_out_idx = idx;
            if (hold_valid) begin
                check_eq("hold_valid", 64'(o_valid), 64'd1);
                check_eq("hold_data", 64'(o_data), 64'(hold_data));
                check_eq("hold_strb", 64'(o_strb), 64'(hold_strb));
            end
            if (o_valid && out_ready) begin
                if (n_out < exp_col.size()) begin
                    check_eq("out_data", 64'(o_data), 64'(beat_data(salt, exp_col[n_out], exp_k[n_out])));
                    check_eq("out_strb", 64'(o_strb), 64'(beat_strb(salt, exp_col[n_out], exp_k[n_out])));
                    if (u == 0) check_eq("col_idx", 64'(o_idx), 64'(exp_col[n_out]));
                end else begin
                    check_eq("extra_beat", 64'(n_out + 1), 64'(exp_col.size()));
                end
                n_out++;
                last_out_idx = idx;
            end
            hold_valid = o_valid && !out_ready;
            hold_data  = o_data;
            hold_strb  = o_strb;
            if (o_done) begin
                done_idx = idx;
                break;
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < NR_COL; c++) if (hs[c]) src_k[c]++;
            if (clear_at > 0 && n_out == clear_at) begin
                clear = 1'b1;
                @(posedge clk);
                #1;
                clear = 1'b0;
                in_valid = '0;
                @(negedge clk);
                check_eq("clr_valid", 64'(o_valid), 64'd0);
                check_eq("clr_busy", 64'(o_busy), 64'd0);
                check_eq("clr_done", 64'(o_done), 64'd0);
                check_eq("clr_ready", 64'(o_ready), 64'd0);
                check_eq("clr_idx", 64'(o_idx), 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    check_eq("clr_no_done", 64'(o_done), 64'd0);
                end
                return;
            end
            for (int c = 0; c < NR_COL; c++) begin
                if (!(in_valid[c] && !hs[c])) in_valid[c] = ($urandom_range(99) < vpct);
                set_beat(c, src_k[c]);
            end
            out_ready = ($urandom_range(99) < rpct);
            idx++;
        end

        $display("job unit=%0d mask=%03h rounds=%0d beats=%0d/%0d done_idx=%0d busy=%0d",
                 u, m, r, n_out, exp_col.size(), done_idx, busy_cnt);
        check_eq("done_seen", 64'(done_idx >= 0), 64'd1);
        check_eq("beat_count", 64'(n_out), 64'(exp_col.size()));
        for (int c = 0; c < NR_COL; c++)
            check_eq("consumed", 64'(src_k[c]), 64'(m[c] ? r : 0));
        if (exp_col.size() > 0) begin
            check_eq("done_latency", 64'(done_idx), 64'(last_out_idx + 1));
        end else begin
            check_eq("empty_done", 64'(done_idx), 64'd0);
            check_eq("empty_busy", 64'(busy_cnt), 64'd0);
        end
        if (vpct == 100 && rpct == 100 && exp_col.size() > 0) begin
            check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_col.size() + u));
            check_eq("first_latency", 64'(first_out_idx), 64'(first_in_idx + u));
            check_eq("contiguous", 64'(last_out_idx - first_out_idx), 64'(exp_col.size() - 1));
        end
        in_valid = '0;
        @(negedge clk);
        check_eq("done_pulse", 64'(o_done), 64'd0);
        check_eq("idle_busy", 64'(o_busy), 64'd0);
    endtask

    initial begin
        for (int c = 0; c < NR_COL; c++) set_beat(c, c + 1);
        in_valid = '1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = '0;
        @(negedge clk);
        check_eq("rst_ready0", 64'(rdy0), 64'd0);
        check_eq("rst_valid0", 64'(ov0), 64'd0);
        check_eq("rst_data0", 64'(od0), 64'd0);
        check_eq("rst_strb0", 64'(os0), 64'd0);
        check_eq("rst_idx0", 64'(ci0), 64'd0);
        check_eq("rst_busy0", 64'(busy0), 64'd0);
        check_eq("rst_done0", 64'(done0), 64'd0);
        check_eq("rst_ready1", 64'(rdy1), 64'd0);
        check_eq("rst_valid1", 64'(ov1), 64'd0);
        check_eq("rst_data1", 64'(od1), 64'd0);
        check_eq("rst_strb1", 64'(os1), 64'd0);
        check_eq("rst_idx1", 64'(ci1), 64'd0);
        check_eq("rst_busy1", 64'(busy1), 64'd0);
        check_eq("rst_done1", 64'(done1), 64'd0);

        // Pass-through unit
        run_job(0, 9'h1FF, 2, 100, 100, 0);
        run_job(0, 9'b100010010, 3, 100, 100, 0);
        for (int i = 0; i < 4; i++)
            run_job(0, NR_COL'($urandom_range(511, 1)), int'($urandom_range(4, 1)), 70, 50, 0);
        run_job(0, 9'h000, 5, 100, 100, 0);
        run_job(0, 9'h1FF, 0, 100, 100, 0);
        run_job(0, 9'h010, 255, 80, 60, 0);

        // Registered-output unit
        run_job(1, 9'h1FF, 1, 100, 100, 0);
        run_job(1, 9'h1FF, 2, 100, 100, 5);
        run_job(1, 9'b100010010, 3, 100, 100, 0);
        for (int i = 0; i < 4; i++)
            run_job(1, NR_COL'($urandom_range(511, 1)), int'($urandom_range(4, 1)), 70, 50, 0);
        run_job(1, 9'h000, 5, 100, 100, 0);
        run_job(1, 9'h1FF, 0, 100, 100, 0);
        run_job(1, 9'h100, 255, 90, 70, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
